// File: rtl/rv32i_control_fsm_if.sv
// Control-sequencer bundle: shared memory port handshake plus datapath enables and selects.
// Latency: wires only, no storage.
// Backpressure: mem_ready from the memory side holds mem_req and stalls the sequencer.
interface rv32i_control_fsm_if;
    logic        start;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        illegal;
    logic [31:0] instret;

    // Sequencer side: consumes IR class and memory handshake, drives every control line.
    modport master (
        input  start, opcode, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, rf_we, wb_sel, halted, illegal, instret
    );

    // Datapath / memory side: the mirror image.
    modport slave (
        output start, opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, rf_we, wb_sel, halted, illegal, instret
    );
endinterface

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control sequencer: IR/PC/regfile enables, mux selects, shared memory port, instret.
// Latency: 3 cycles branch/jump, 4 ALU/LUI/FENCE/store, 5 load, plus one per memory wait cycle.
// Backpressure: FETCH and MEM hold mem_req until mem_ready; mem_ready in any other state is ignored.
module rv32i_control_fsm #(
    parameter bit          RESET_STATE_FETCH = 1'b1,
    // Value the retired-instruction counter takes on reset.
    parameter logic [31:0] INSTRET_RST_VAL   = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_control_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_LOAD,
        C_FENCE,
        C_OPIMM,
        C_AUIPC,
        C_STORE,
        C_OP,
        C_LUI,
        C_BRANCH,
        C_JALR,
        C_JAL,
        C_SYSTEM,
        C_ILLEGAL
    } cls_t;

    localparam state_t RST_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        illegal_q;
    logic        illegal_d;
    cls_t        cls;
    logic        retire;

    logic        mem_req_c;
    logic        mem_we_c;
    logic        mem_addr_sel_c;
    logic        ir_we_c;
    logic        pc_we_c;
    logic [1:0]  pc_src_c;
    logic        alu_src_a_c;
    logic        alu_src_b_c;
    logic        rf_we_c;
    logic [1:0]  wb_sel_c;

    // Classify the latched instruction; anything without 2'b11 low bits or an unknown major opcode is illegal.
    always_comb begin
        cls = C_ILLEGAL;
        if (bus.opcode[1:0] == 2'b11) begin
            case (bus.opcode[6:2])
                5'b00000: cls = C_LOAD;
                5'b00011: cls = C_FENCE;
                5'b00100: cls = C_OPIMM;
                5'b00101: cls = C_AUIPC;
                5'b01000: cls = C_STORE;
                5'b01100: cls = C_OP;
                5'b01101: cls = C_LUI;
                5'b11000: cls = C_BRANCH;
                5'b11001: cls = C_JALR;
                5'b11011: cls = C_JAL;
                5'b11100: cls = C_SYSTEM;
                default:  cls = C_ILLEGAL;
            endcase
        end
    end

    // Next state and per-state control outputs; everything stays at its default while rst is high,
    // which is what abandons an in-flight memory request on reset.
    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        retire         = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        pc_src_c       = 2'd0;
        alu_src_a_c    = 1'b0;
        alu_src_b_c    = 1'b0;
        rf_we_c        = 1'b0;
        wb_sel_c       = 2'd0;

        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_FETCH;
                    end
                end

                S_FETCH: begin
                    mem_req_c = 1'b1;
                    ir_we_c   = bus.mem_ready;
                    if (bus.mem_ready) begin
                        state_d = S_DECODE;
                    end
                end

                // Regfile read and immediate generation settle here; no enables.
                S_DECODE: begin
                    if (cls == C_ILLEGAL) begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end else if (cls == C_SYSTEM) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (cls)
                        C_OP: begin
                            state_d = S_WB;
                        end
                        C_OPIMM: begin
                            alu_src_b_c = 1'b1;
                            state_d     = S_WB;
                        end
                        C_AUIPC: begin
                            alu_src_a_c = 1'b1;
                            alu_src_b_c = 1'b1;
                            state_d     = S_WB;
                        end
                        C_LUI, C_FENCE: begin
                            state_d = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_b_c = 1'b1;
                            state_d     = S_MEM;
                        end
                        C_BRANCH: begin
                            pc_we_c  = 1'b1;
                            pc_src_c = bus.branch_taken ? 2'd1 : 2'd0;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        // Link write uses the pre-update PC, so rd and PC commit in the same cycle.
                        C_JAL, C_JALR: begin
                            pc_we_c  = 1'b1;
                            pc_src_c = (cls == C_JALR) ? 2'd2 : 2'd1;
                            rf_we_c  = 1'b1;
                            wb_sel_c = 2'd2;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default: begin
                            state_d = S_FETCH;
                        end
                    endcase
                end

                // ALU operand select is held so the load/store address stays stable across waits.
                S_MEM: begin
                    mem_req_c      = 1'b1;
                    mem_addr_sel_c = 1'b1;
                    alu_src_b_c    = 1'b1;
                    mem_we_c       = (cls == C_STORE);
                    if (bus.mem_ready) begin
                        if (cls == C_STORE) begin
                            pc_we_c  = 1'b1;
                            pc_src_c = 2'd0;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end

                S_WB: begin
                    pc_we_c  = 1'b1;
                    pc_src_c = 2'd0;
                    rf_we_c  = (cls != C_FENCE);
                    if (cls == C_LOAD) begin
                        wb_sel_c = 2'd1;
                    end else if (cls == C_LUI) begin
                        wb_sel_c = 2'd3;
                    end else begin
                        wb_sel_c = 2'd0;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end

                S_TRAP: begin
                    state_d = S_TRAP;
                end

                default: begin
                    state_d = RST_STATE;
                end
            endcase
        end
    end

    // Retired-instruction counter wraps naturally at 32 bits.
    assign instret_d = retire ? (instret_q + 32'd1) : instret_q;

    // State, sticky illegal flag and instret registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            instret_q <= INSTRET_RST_VAL;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.mem_req      = mem_req_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_addr_sel = mem_addr_sel_c;
    assign bus.ir_we        = ir_we_c;
    assign bus.pc_we        = pc_we_c;
    assign bus.pc_src       = pc_src_c;
    assign bus.alu_src_a    = alu_src_a_c;
    assign bus.alu_src_b    = alu_src_b_c;
    assign bus.rf_we        = rf_we_c;
    assign bus.wb_sel       = wb_sel_c;
    assign bus.halted       = (state_q == S_TRAP);
    assign bus.illegal      = illegal_q;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Bench for the RV32I control sequencer: directed cases then randomized instruction streams.
// Expected per-cycle outputs come from an instruction-level plan built from the opcode table.
// Memory waits and don't-care inputs are randomized; a second instance covers IDLE start and wrap.
module tb_rv32i_control_fsm;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rv32i_control_fsm_if a_if ();
    rv32i_control_fsm_if b_if ();

    rv32i_control_fsm dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    rv32i_control_fsm #(
        .RESET_STATE_FETCH (1'b0),
        .INSTRET_RST_VAL   (32'hFFFF_FFFF)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    localparam int K_LOAD = 0, K_FENCE = 1, K_OPIMM = 2, K_AUIPC = 3, K_STORE = 4, K_OP = 5;
    localparam int K_LUI = 6, K_BRANCH = 7, K_JALR = 8, K_JAL = 9, K_SYS = 10, K_ILL = 11;

    logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic       ir;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic       sa;
        logic       sb;
        logic       rf;
        logic [1:0] wb;
        logic       halt;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [6:0]  op;
        logic        rdy;
        logic        bt;
        exp_t        exp;
        logic [31:0] ins;
    } step_t;

    step_t       q[$];
    logic [31:0] m_instret;
    logic        m_ill;

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'h03:   return K_LOAD;
            7'h0F:   return K_FENCE;
            7'h13:   return K_OPIMM;
            7'h17:   return K_AUIPC;
            7'h23:   return K_STORE;
            7'h33:   return K_OP;
            7'h37:   return K_LUI;
            7'h63:   return K_BRANCH;
            7'h67:   return K_JALR;
            7'h6F:   return K_JAL;
            7'h73:   return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic rnd1();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [6:0] rnd7();
        logic [31:0] r;
        r = $urandom;
        return r[6:0];
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o = {a_if.mem_req, a_if.mem_we, a_if.mem_addr_sel, a_if.ir_we, a_if.pc_we, a_if.pc_src,
             a_if.alu_src_a, a_if.alu_src_b, a_if.rf_we, a_if.wb_sel, a_if.halted, a_if.illegal};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic rdy, input logic bt, input exp_t e, input logic retire);
        step_t s;
        s.op  = op;
        s.rdy = rdy;
        s.bt  = bt;
        s.exp = e;
        s.ins = m_instret;
        q.push_back(s);
        if (retire) m_instret = m_instret + 32'd1;
    endtask

    // Expand one instruction into its cycle-by-cycle expected control outputs.
    task automatic plan(input logic [6:0] op, input int fw, input int mw, input logic bt);
        int   c;
        exp_t e;
        logic bt_x;
        logic ret;
        logic st;
        c = cls_of(op);
        e = '0;
        e.req = 1'b1;
        for (int i = 0; i < fw; i++) push(rnd7(), 1'b0, rnd1(), e, 1'b0);
        e.ir = 1'b1;
        push(rnd7(), 1'b1, rnd1(), e, 1'b0);
        e = '0;
        push(op, rnd1(), rnd1(), e, 1'b0);
        if (c == K_ILL || c == K_SYS) begin
            m_ill  = (c == K_ILL);
            e.halt = 1'b1;
            e.ill  = m_ill;
            for (int i = 0; i < 3; i++) push(op, rnd1(), rnd1(), e, 1'b0);
            return;
        end
        bt_x = rnd1();
        ret  = 1'b0;
        case (c)
            K_OPIMM:          e.sb = 1'b1;
            K_AUIPC:          begin e.sa = 1'b1; e.sb = 1'b1; end
            K_LOAD, K_STORE:  e.sb = 1'b1;
            K_BRANCH:         begin bt_x = bt; e.pcwe = 1'b1; e.pcsrc = bt ? 2'd1 : 2'd0; ret = 1'b1; end
            K_JAL:            begin e.pcwe = 1'b1; e.pcsrc = 2'd1; e.rf = 1'b1; e.wb = 2'd2; ret = 1'b1; end
            K_JALR:           begin e.pcwe = 1'b1; e.pcsrc = 2'd2; e.rf = 1'b1; e.wb = 2'd2; ret = 1'b1; end
            default:          ;
        endcase
        push(op, rnd1(), bt_x, e, ret);
        if (ret) return;
        if (c == K_LOAD || c == K_STORE) begin
            st = (c == K_STORE);
            e = '0;
            e.req = 1'b1;
            e.we = st;
            e.asel = 1'b1;
            e.sb = 1'b1;
            for (int i = 0; i < mw; i++) push(op, 1'b0, rnd1(), e, 1'b0);
            e.pcwe = st;
            push(op, 1'b1, rnd1(), e, st);
            if (st) return;
        end
        e = '0;
        e.pcwe = 1'b1;
        e.rf = (c != K_FENCE);
        e.wb = (c == K_LOAD) ? 2'd1 : ((c == K_LUI) ? 2'd3 : 2'd0);
        push(op, rnd1(), rnd1(), e, 1'b1);
    endtask

    // Apply planned steps starting at a negedge; nmax < 0 runs the whole plan.
    task automatic run_plan(input string tag, input int nmax);
        step_t s;
        int    n;
        n = 0;
        while (q.size() > 0 && (nmax < 0 || n < nmax)) begin
            s = q.pop_front();
            a_if.opcode       = s.op;
            a_if.mem_ready    = s.rdy;
            a_if.branch_taken = s.bt;
            #1;
            chk($sformatf("%s.c%0d.ctl", tag, n), obs_a(), s.exp);
            chk($sformatf("%s.c%0d.instret", tag, n), a_if.instret, s.ins);
            @(negedge clk);
            n++;
        end
        q.delete();
        if (nmax < 0) chk({tag, ".instret_end"}, a_if.instret, m_instret);
    endtask

    task automatic do_reset(input string tag);
        exp_t o;
        rst_a = 1'b1;
        a_if.mem_ready = rnd1();
        #1;
        o = obs_a();
        chk({tag, ".rst_enables"}, {o.req, o.ir, o.pcwe, o.rf}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        m_instret = 32'd0;
        m_ill = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        exp_t       o;
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.start = 1'b0; a_if.opcode = 7'h00; a_if.mem_ready = 1'b0; a_if.branch_taken = 1'b0;
        b_if.start = 1'b0; b_if.opcode = 7'h00; b_if.mem_ready = 1'b0; b_if.branch_taken = 1'b0;
        m_instret = 32'd0;
        m_ill = 1'b0;
        repeat (2) @(negedge clk);
        a_if.mem_ready = 1'b1;
        #1;
        chk("reset.ctl", obs_a(), 32'd0);
        chk("reset.instret", a_if.instret, 32'd0);
        chk("reset_b.mem_req", b_if.mem_req, 32'd0);

        // Instance B: parks in IDLE until start, counter preloaded to all-ones, ADDI wraps it.
        @(negedge clk);
        rst_b = 1'b0;
        b_if.mem_ready = 1'b1;
        #1;
        chk("b.idle0.mem_req", b_if.mem_req, 32'd0);
        chk("b.idle0.instret", b_if.instret, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("b.idle1.mem_req", b_if.mem_req, 32'd0);
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        b_if.opcode = 7'h13;
        #1;
        chk("b.fetch.req_ir", {b_if.mem_req, b_if.ir_we}, 32'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("b.wb.pc_rf", {b_if.pc_we, b_if.rf_we, b_if.wb_sel}, 32'hC);
        chk("b.wb.instret", b_if.instret, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("b.wrap.instret", b_if.instret, 32'd0);
        chk("b.wrap.fetch", b_if.mem_req, 32'd1);
        rst_b = 1'b1;

        // Instance A directed cases.
        @(negedge clk);
        rst_a = 1'b0;
        plan(7'h13, 0, 0, 1'b0);  // ADDI x1,x0,5 (0x00500093)
        run_plan("addi", -1);
        plan(7'h03, 2, 3, 1'b0);  // LW x2,0(x1) (0x0000A103)
        run_plan("lw", -1);
        plan(7'h63, 0, 0, 1'b1);  // BEQ taken (0x00208463)
        run_plan("beq_t", -1);
        plan(7'h63, 0, 0, 1'b0);  // BEQ not taken
        run_plan("beq_nt", -1);
        plan(7'h67, 0, 0, 1'b0);  // JALR x1,0(x1) (0x000080E7)
        run_plan("jalr", -1);
        plan(7'h00, 0, 0, 1'b0);  // low opcode bits 00
        run_plan("illegal", -1);
        do_reset("illegal");
        plan(7'h73, 1, 0, 1'b0);  // ECALL (0x00000073)
        run_plan("ecall", -1);
        do_reset("ecall");

        // Reset while a store is waiting on memory.
        plan(7'h23, 0, 5, 1'b0);
        run_plan("sw_rst", 5);
        rst_a = 1'b1;
        a_if.mem_ready = 1'b0;
        #1;
        chk("sw_rst.req_pcwe", {a_if.mem_req, a_if.pc_we}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        o = obs_a();
        chk("sw_rst.fetch", {o.req, o.asel, o.we, o.pcwe}, 32'h8);
        chk("sw_rst.instret", a_if.instret, 32'd0);
        m_instret = 32'd0;
        m_ill = 1'b0;

        // Randomized instruction stream with random memory waits.
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 11);
            if (sel == 11) begin
                do op = rnd7(); while (cls_of(op) != K_ILL);
            end else begin
                op = ops[sel];
            end
            plan(op, $urandom_range(0, 2), $urandom_range(0, 2), rnd1());
            run_plan($sformatf("rnd%0d_op%02h", k, op), -1);
            if (cls_of(op) == K_ILL || cls_of(op) == K_SYS) do_reset($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
